rr_arbiter_ctrl: RTL and testbench

- Clocked round-robin arbiter that shares a single resource among N requesters.
- Grants are registered and held until the owner releases them, or until a hold-time limit expires while other requesters wait.
- Priority rotates to the requester after the last owner. Selection uses a circular ripple-priority chain (grant = request AND carry-in; carry passes only when not requesting), started at the rotating pointer.

---
 rtl/rr_arbiter_ctrl.sv | 90 +++++++++
 tb/tb_rr_arbiter_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter sharing one resource among N requesters.
// Grants are registered and held until the owner drops its request,
// or until MAX_HOLD consecutive cycles pass while someone else waits.
// Priority rotates to the index after the last owner on every release.
module rr_arbiter_ctrl #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 4,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy
);

  localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_ptr;
  logic [HCW-1:0] r_hold;

  logic [IDW-1:0] w_owner_id;
  logic [IDW-1:0] w_next_ptr;
  logic [N-1:0]   w_pending;
  logic           w_busy;
  logic           w_owner_req;
  logic           w_timeout;
  logic           w_release;

  // Circular ripple-priority chain starting at ptr: a bit wins when it
  // requests and still holds the carry; the carry only passes idle bits.
  function automatic logic [N-1:0] f_arb(input logic [N-1:0] mask,
                                         input logic [IDW-1:0] ptr);
    logic [N-1:0] g;
    logic         carry;
    int           idx;
    g     = '0;
    carry = 1'b1;
    for (int k = 0; k < N; k++) begin
      idx    = (int'(ptr) + k) % N;
      g[idx] = mask[idx] & carry;
      carry  = carry & ~mask[idx];
    end
    return g;
  endfunction

  // Encode the one-hot grant register into the owner index (0 when idle).
  always_comb begin
    w_owner_id = '0;
    for (int i = 0; i < N; i++) begin
      if (r_gnt[i]) w_owner_id = w_owner_id | IDW'(i);
    end
  end

  assign w_busy      = |r_gnt;
  assign w_pending   = req & ~r_gnt;
  assign w_owner_req = |(req & r_gnt);
  assign w_timeout   = (MAX_HOLD != 0) && (r_hold == HOLD_LAST) && (|w_pending);
  assign w_release   = w_busy && (!w_owner_req || w_timeout);
  assign w_next_ptr  = IDW'((int'(w_owner_id) + 1) % N);

  // Grant register, rotating pointer and hold counter update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt  <= '0;
      r_ptr  <= '0;
      r_hold <= '0;
    end else if (!w_busy) begin
      if (|req) r_gnt <= f_arb(req, r_ptr);
      r_hold <= '0;
    end else if (w_release) begin
      // Back-to-back handover; an empty pending set yields an all-zero grant.
      r_ptr  <= w_next_ptr;
      r_gnt  <= f_arb(w_pending, w_next_ptr);
      r_hold <= '0;
    end else if ((MAX_HOLD != 0) && (|w_pending)) begin
      r_hold <= r_hold + 1'b1;
    end else begin
      r_hold <= '0;
    end
  end

  assign gnt    = r_gnt;
  assign gnt_id = w_owner_id;
  assign busy   = w_busy;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Bench for rr_arbiter_ctrl: directed scenarios plus a random request
// stream compared against a behavioural round-robin model.
module tb_rr_arbiter_ctrl;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = 2;
  localparam int BOUND    = (N - 1) * MAX_HOLD + 1;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;

  int n_checks;
  int n_fail;

  // Behavioural model: owner index (-1 = idle), priority pointer, hold age.
  int m_owner;
  int m_ptr;
  int m_hold;

  rr_arbiter_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_arb(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++) begin
      if (mask[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    logic [N-1:0] pend;
    bit           rel;
    if (m_owner < 0) begin
      if (r != 0) m_owner = model_arb(r, m_ptr);
      m_hold = 0;
    end else begin
      pend = r;
      pend[m_owner] = 1'b0;
      rel = !r[m_owner] || (MAX_HOLD != 0 && m_hold == MAX_HOLD - 1 && pend != 0);
      if (rel) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = model_arb(pend, m_ptr);
        m_hold  = 0;
      end else begin
        m_hold = (pend != 0) ? m_hold + 1 : 0;
      end
    end
  endtask

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  // One clock edge: advance the model on the pre-edge req, compare after the edge.
  task automatic step();
    logic [N-1:0] r;
    r = req;
    @(posedge clk);
    model_step(r);
    #1;
    check_eq("model_gnt", 32'(gnt), 32'(model_gnt()));
    check_eq("model_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check_eq("model_busy", 32'(busy), 32'(m_owner >= 0));
  endtask

  task automatic do_reset();
    req     = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rp, gp;
    int           age[N];
    n_checks = 0;
    n_fail   = 0;
    req      = '0;
    reset_n  = 1'b0;
    model_reset();

    // Reset values and idle behaviour.
    do_reset();
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("idle_gnt", 32'(gnt), 32'd0);
      check_eq("idle_id", 32'(gnt_id), 32'd0);
    end

    // Asynchronous reset clears a live grant immediately.
    req = 4'b0001;
    step();
    check_eq("live_gnt", 32'(gnt), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_gnt", 32'(gnt), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd0);
    model_reset();
    req = '0;
    #1 reset_n = 1'b1;

    // Basic grant and handover.
    do_reset();
    req = 4'b1010;
    step();
    check_eq("t2_first", 32'(gnt), 32'h2);
    check_eq("t2_id1", 32'(gnt_id), 32'd1);
    req = 4'b1000;
    step();
    check_eq("t2_hand", 32'(gnt), 32'h8);
    check_eq("t2_id3", 32'(gnt_id), 32'd3);
    req = 4'b0000;
    step();
    check_eq("t2_idle", 32'(gnt), 32'd0);

    // Pointer wrapped to 0: from idle requester 0 wins over 2.
    req = 4'b0101;
    step();
    check_eq("t2_ptr0", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();

    // Timeout rotation with all requesters active.
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      check_eq("t3_rot", 32'(gnt), 32'(1 << ((c / 4) % 4)));
    end

    // Sole requester never times out.
    req = 4'b0000;
    step();
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      step();
      check_eq("t4_sole", 32'(gnt), 32'h4);
    end

    // Owner 2 releases as 0 and 3 arrive: scan starts at 3.
    req = 4'b1001;
    step();
    check_eq("t5_simul", 32'(gnt), 32'h8);
    check_eq("t5_id", 32'(gnt_id), 32'd3);
    req = 4'b0000;
    step();

    // Random stream with protocol and starvation checks.
    do_reset();
    for (int i = 0; i < N; i++) age[i] = 0;
    gp = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i])      req[i] = ($urandom_range(99) < 30);
        else if (gnt[i])  req[i] = !($urandom_range(99) < 30);
        else              req[i] = !($urandom_range(99) < 3);
      end
      rp = req;
      step();
      check_eq("onehot0", 32'($onehot0(gnt)), 32'd1);
      check_eq("gnt_in_req", 32'((gnt & ~rp) == 0), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (!rp[i]) begin
          age[i] = 0;
        end else if (gnt[i]) begin
          if (!gp[i]) check_eq("starve_ok", 32'(age[i] + 1 <= BOUND), 32'd1);
          age[i] = 0;
        end else begin
          age[i]++;
          if (age[i] > BOUND) begin
            check_eq("starve_ok", 32'd0, 32'd1);
            age[i] = 0;
          end
        end
      end
      gp = gnt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
